alu_pipe: RTL and testbench
===========================

# alu_pipe

Fully pipelined, parametrised integer ALU execution unit. It sits between an ALU reservation station and the CDB/ROB, and accepts one instruction per cycle. Each instruction completes after a configurable fixed latency. The unit applies CDB back-pressure, resolves every branch (taken and not-taken) to the branch-misprediction unit, and squashes in-flight work on pipeline flush.

## Interface
- `LATENCY`, default 2: pipeline depth in cycles, ≥1.
- `DATA_W`, default `REG_VAL_WIDTH`: operand/result width.
- `PREG_W`, default `PHYSICAL_REG_NUM_WIDTH`: destination physical register width.
- `TAG_W`, default `ROB_SIZE_WIDTH`: ROB tag width.
- `ADDR_W`, default `INST_ADDR_WIDTH`: PC width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `rs_valid` in 1: issue request.
- `alu_ready` out 1: unit accepts an issue this cycle.
- `src_reg1_val`, `src_reg2_val` in DATA_W: operands.
- `immediate` in DATA_W: immediate value.
- `control` in control_t: uses `alu_op`, `alu_src`, `is_branch_op`.
- `dst_reg_addr` in PREG_W: destination register.
- `pc_in` in ADDR_W: instruction PC.
- `new_inst_tag_in` in TAG_W: ROB tag.
- `flush` in 1: squash all in-flight instructions.
- `cdb_ready` in 1: CDB accepts the result.
- `alu_valid` out 1: non-branch result valid.
- `result_val` out DATA_W, `result_addr` out PREG_W: result and destination register.
- `new_inst_tag_out` out TAG_W: tag of the instruction at the output.
- `br_valid` out 1: branch resolved.
- `br_taken` out 1: branch taken.
- `pc_out` out ADDR_W: branch target.

## Operation
- Operand 2 is `src_reg2_val` if `alu_src == src_reg2`, otherwise `immediate`. Operand 1 is `src_reg1_val`.
- add_op and sub_op wrap modulo 2^DATA_W.
- sll_op, srl_op and sra_op use the low $clog2(DATA_W) bits of operand 2 as the shift amount. sra_op is an arithmetic shift (sign-filling).
- slt_op compares signed; sltu_op compares unsigned. The result is 1 or 0, zero-extended.
- xor_op, or_op and and_op are bitwise.
- Branch ops (`is_branch_op`=1) are eq_op, not_eq_op, less_than_op (signed) and greater_equal_than_op (signed).
  - Condition true: `br_taken`=1 and `pc_out` = `pc_in` + (`immediate`<<1), truncated to ADDR_W.
  - Condition false: `br_taken`=0 and `pc_out` = `pc_in`+4.
- Branches never assert `alu_valid`.
- An unknown alu_op produces result 0 with `alu_valid` asserted (non-branch) or not-taken (branch).
- Computation happens in stage 0. Stages 1..LATENCY-1 only carry the data along. Each stage holds a valid bit, is_branch, result, target, taken, dst and tag.

## Timing
- Issue is accepted when `rs_valid && alu_ready`.
- The accepted instruction reaches the output stage exactly LATENCY cycles later, provided there is no stall.
- Throughput is 1 instruction per cycle.
- stall = output stage valid && !is_branch && !`cdb_ready`.
  - While stalled, every stage holds its contents and `alu_ready`=0.
  - Otherwise `alu_ready`=1.
  - A bubble in an earlier stage is not collapsed while stalled.
- Output stage:
  - `alu_valid` = valid && !is_branch.
  - `br_valid` = valid && is_branch.
  - Branch outputs are never stalled and are consumed in the cycle they are presented.
- The output data and tag stay stable while `alu_valid` is held by a stall.
- `flush`: all stage valid bits clear on the next edge. An issue in the same cycle as `flush` is dropped. `alu_ready` is unaffected by `flush`.
- Reset values:
  - All valid bits are 0, so `alu_valid`=`br_valid`=0.
  - `result_val`, `result_addr`, `new_inst_tag_out`, `pc_out` and `br_taken` are 0.
  - `alu_ready`=1 after reset is released.
- Asserting reset mid-operation discards all in-flight instructions asynchronously.

## Configuration
- `ALU_PIPE_FLUSH_EN`:
  - Defined: `flush` behaves as described under Timing.
  - Undefined: `flush` is ignored, and in-flight instructions always complete.

## Test plan
- LATENCY=2, `ALU_PIPE_FLUSH_EN` defined.
- Issue add_op, 5 + 7, dst 3, tag 1, `cdb_ready`=1 → `alu_valid`=1 two cycles later with `result_val`=12, `result_addr`=3, `new_inst_tag_out`=1.
- Back-to-back issue of sra_op on 0x80000000 by 4, then sltu_op with 0xFFFFFFFF vs 1, then slt_op with the same operands → results 0xF8000000, 0, 1 on consecutive cycles.
- eq_op branch with equal operands, `pc_in`=0x100, `immediate`=8 → `br_valid`=1, `br_taken`=1, `pc_out`=0x110, `alu_valid`=0. The same branch with unequal operands → `br_taken`=0, `pc_out`=0x104.
- Three back-to-back adds issued with `cdb_ready`=0 for 3 cycles → `alu_ready`=0 while stalled, the first result is held stable, and all three results emerge in order after `cdb_ready` rises.
- Two instructions in flight, `flush` pulsed for 1 cycle together with a new issue → no `alu_valid` or `br_valid` for the next 3 cycles.
- Assert `reset` asynchronously with 2 instructions in flight → outputs go to 0 immediately, and `alu_ready`=1 after release.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: fully pipelined integer ALU execution unit.
// Computes in stage 0, carries results through LATENCY stages, stalls on
// CDB back-pressure for non-branch results and resolves branches without
// stalling. Optional macro ALU_PIPE_FLUSH_EN enables squashing of in-flight
// work on flush; when it is undefined, flush is ignored.

package alu_pipe_pkg;
    localparam int REG_VAL_WIDTH          = 32;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int ROB_SIZE_WIDTH         = 5;
    localparam int INST_ADDR_WIDTH        = 32;

    typedef enum logic [3:0] {
        add_op                = 4'd0,
        sub_op                = 4'd1,
        sll_op                = 4'd2,
        srl_op                = 4'd3,
        sra_op                = 4'd4,
        slt_op                = 4'd5,
        sltu_op               = 4'd6,
        xor_op                = 4'd7,
        or_op                 = 4'd8,
        and_op                = 4'd9,
        eq_op                 = 4'd10,
        not_eq_op             = 4'd11,
        less_than_op          = 4'd12,
        greater_equal_than_op = 4'd13
    } alu_op_t;

    typedef enum logic {
        src_reg2 = 1'b0,
        src_imm  = 1'b1
    } alu_src_t;

    typedef struct packed {
        alu_op_t  alu_op;
        alu_src_t alu_src;
        logic     is_branch_op;
    } control_t;
endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DATA_W  = REG_VAL_WIDTH,
    parameter int PREG_W  = PHYSICAL_REG_NUM_WIDTH,
    parameter int TAG_W   = ROB_SIZE_WIDTH,
    parameter int ADDR_W  = INST_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rs_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] src_reg1_val,
    input  logic [DATA_W-1:0] src_reg2_val,
    input  logic [DATA_W-1:0] immediate,
    input  control_t          control,
    input  logic [PREG_W-1:0] dst_reg_addr,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [TAG_W-1:0]  new_inst_tag_in,
    input  logic              flush,
    input  logic              cdb_ready,
    output logic              alu_valid,
    output logic [DATA_W-1:0] result_val,
    output logic [PREG_W-1:0] result_addr,
    output logic [TAG_W-1:0]  new_inst_tag_out,
    output logic              br_valid,
    output logic              br_taken,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic              valid;
        logic              is_branch;
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] target;
        logic              taken;
        logic [PREG_W-1:0] dst;
        logic [TAG_W-1:0]  tag;
    } stage_t;

    stage_t            st [LATENCY];
    stage_t            st0_next;
    stage_t            out_st;
    logic              stall;
    logic              accept;
    logic              flush_act;
    logic [DATA_W-1:0] op2;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] res;
    logic              cond;
    logic              lt_s;
    logic              lt_u;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] target;

`ifdef ALU_PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_act    = 1'b0;
`endif

    // Handshake: an issue is taken on a clock edge where rs_valid && alu_ready.
    // A non-branch result is consumed on an edge where alu_valid && cdb_ready;
    // until then the whole pipe freezes and alu_ready drops. Branch results
    // are consumed unconditionally in the cycle they are shown.
    assign out_st    = st[LATENCY-1];
    assign stall     = out_st.valid && !out_st.is_branch && !cdb_ready;
    assign alu_ready = !stall;
    assign accept    = rs_valid && alu_ready;

    assign lt_s     = $signed(src_reg1_val) < $signed(op2);
    assign lt_u     = src_reg1_val < op2;
    assign imm_addr = ADDR_W'(immediate);

    // Stage-0 execute: operand select, ALU result, branch condition and target.
    always_comb begin
        op2   = (control.alu_src == src_reg2) ? src_reg2_val : immediate;
        shamt = op2[SH_W-1:0];
        res   = '0;
        cond  = 1'b0;
        if (!control.is_branch_op) begin
            case (control.alu_op)
                add_op:  res = src_reg1_val + op2;
                sub_op:  res = src_reg1_val - op2;
                sll_op:  res = src_reg1_val << shamt;
                srl_op:  res = src_reg1_val >> shamt;
                sra_op:  res = $signed(src_reg1_val) >>> shamt;
                slt_op:  res = {{(DATA_W-1){1'b0}}, lt_s};
                sltu_op: res = {{(DATA_W-1){1'b0}}, lt_u};
                xor_op:  res = src_reg1_val ^ op2;
                or_op:   res = src_reg1_val | op2;
                and_op:  res = src_reg1_val & op2;
                default: res = '0;
            endcase
        end else begin
            case (control.alu_op)
                eq_op:                 cond = (src_reg1_val == op2);
                not_eq_op:             cond = (src_reg1_val != op2);
                less_than_op:          cond = lt_s;
                greater_equal_than_op: cond = !lt_s;
                default:               cond = 1'b0;
            endcase
        end
        target = cond ? (pc_in + (imm_addr << 1)) : (pc_in + ADDR_W'(4));
    end

    // Stage-0 payload built from the execute results.
    always_comb begin
        st0_next           = '0;
        st0_next.valid     = accept;
        st0_next.is_branch = control.is_branch_op;
        st0_next.result    = res;
        st0_next.target    = target;
        st0_next.taken     = cond;
        st0_next.dst       = dst_reg_addr;
        st0_next.tag       = new_inst_tag_in;
    end

    // Pipeline registers: flush clears valids, stall freezes, else shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i] <= '0;
            end
        end else if (flush_act) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            st[0] <= st0_next;
            for (int i = 1; i < LATENCY; i++) begin
                st[i] <= st[i-1];
            end
        end
    end

    assign alu_valid        = out_st.valid && !out_st.is_branch;
    assign br_valid         = out_st.valid && out_st.is_branch;
    assign result_val       = out_st.result;
    assign result_addr      = out_st.dst;
    assign new_inst_tag_out = out_st.tag;
    assign br_taken         = out_st.taken;
    assign pc_out           = out_st.target;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe with an in-bench reference model
// (aged queue of in-flight instructions) checked every cycle, plus literal
// expectations on the observed result and branch streams.

module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int LATENCY = 2;
`ifdef ALU_PIPE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rs_valid;
    logic        alu_ready;
    logic [31:0] src_reg1_val;
    logic [31:0] src_reg2_val;
    logic [31:0] immediate;
    control_t    control;
    logic [5:0]  dst_reg_addr;
    logic [31:0] pc_in;
    logic [4:0]  new_inst_tag_in;
    logic        flush;
    logic        cdb_ready;
    logic        alu_valid;
    logic [31:0] result_val;
    logic [5:0]  result_addr;
    logic [4:0]  new_inst_tag_out;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.LATENCY(LATENCY)) dut (
        .clk              (clk),
        .reset            (reset),
        .rs_valid         (rs_valid),
        .alu_ready        (alu_ready),
        .src_reg1_val     (src_reg1_val),
        .src_reg2_val     (src_reg2_val),
        .immediate        (immediate),
        .control          (control),
        .dst_reg_addr     (dst_reg_addr),
        .pc_in            (pc_in),
        .new_inst_tag_in  (new_inst_tag_in),
        .flush            (flush),
        .cdb_ready        (cdb_ready),
        .alu_valid        (alu_valid),
        .result_val       (result_val),
        .result_addr      (result_addr),
        .new_inst_tag_out (new_inst_tag_out),
        .br_valid         (br_valid),
        .br_taken         (br_taken),
        .pc_out           (pc_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        br;
        logic [31:0] res;
        logic        taken;
        logic [31:0] pc;
        logic [5:0]  dst;
        logic [4:0]  tag;
        int          age;
    } mentry_t;

    mentry_t mq[$];
    bit      m_stall;

    function automatic mentry_t model_exec(input control_t c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm,
                                           input logic [31:0] pc, input logic [5:0] dst,
                                           input logic [4:0] tag);
        mentry_t     e;
        logic [31:0] o2;
        int          sh;
        int          sa;
        int          so2;
        bit          hit;
        o2  = (c.alu_src == src_imm) ? imm : b;
        sh  = int'(o2 % 32);
        sa  = int'(a);
        so2 = int'(o2);
        e.br = c.is_branch_op; e.res = 0; e.taken = 0; e.pc = 0;
        e.dst = dst; e.tag = tag; e.age = 1;
        if (!c.is_branch_op) begin
            case (c.alu_op)
                add_op:  e.res = a + o2;
                sub_op:  e.res = a - o2;
                sll_op:  e.res = a * (32'd1 << sh);
                srl_op:  e.res = a / (33'd1 << sh);
                sra_op:  e.res = 32'(sa >>> sh);
                slt_op:  e.res = (sa < so2) ? 32'd1 : 32'd0;
                sltu_op: e.res = (a < o2) ? 32'd1 : 32'd0;
                xor_op:  e.res = a ^ o2;
                or_op:   e.res = a | o2;
                and_op:  e.res = a & o2;
                default: e.res = 0;
            endcase
        end else begin
            case (c.alu_op)
                eq_op:                 hit = (a == o2);
                not_eq_op:             hit = (a != o2);
                less_than_op:          hit = (sa < so2);
                greater_equal_than_op: hit = (sa >= so2);
                default:               hit = 0;
            endcase
            e.taken = hit;
            e.pc    = hit ? pc + imm * 2 : pc + 4;
        end
        return e;
    endfunction

    // Model advances on the same edges as the DUT, using pre-edge inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_stall = (mq.size() > 0) && (mq[0].age == LATENCY) && !mq[0].br && !cdb_ready;
            if (FLUSH_EN && flush) begin
                mq.delete();
            end else if (!m_stall) begin
                for (int i = 0; i < mq.size(); i++) mq[i].age++;
                if (mq.size() > 0 && mq[0].age > LATENCY) void'(mq.pop_front());
                if (rs_valid)
                    mq.push_back(model_exec(control, src_reg1_val, src_reg2_val, immediate,
                                            pc_in, dst_reg_addr, new_inst_tag_in));
            end
        end
    end

    // ---------------- scoreboard / compare process ----------------
    logic [31:0] exp_q[$];
    logic [32:0] exp_br_q[$];
    logic [31:0] res_log[$];
    logic [32:0] br_log[$];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            bit head_out;
            head_out = (mq.size() > 0) && (mq[0].age == LATENCY);
            check("alu_ready", alu_ready, !(head_out && !mq[0].br && !cdb_ready));
            check("alu_valid", alu_valid, head_out && !mq[0].br);
            check("br_valid", br_valid, head_out && mq[0].br);
            if (head_out && mq[0].br) begin
                check("br_taken", br_taken, mq[0].taken);
                check("pc_out", pc_out, mq[0].pc);
            end else if (head_out) begin
                check("result_val", result_val, mq[0].res);
                check("result_addr", result_addr, mq[0].dst);
                check("tag_out", new_inst_tag_out, mq[0].tag);
            end
            if (alu_valid && cdb_ready) res_log.push_back(result_val);
            if (br_valid) br_log.push_back({br_taken, pc_out});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input alu_op_t op, input logic imm_src, input logic br,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [5:0] dst, input logic [4:0] tag);
        int   budget;
        logic acc;
        budget = 50;
        rs_valid        = 1'b1;
        control         = '{alu_op: op, alu_src: imm_src ? src_imm : src_reg2, is_branch_op: br};
        src_reg1_val    = a;
        src_reg2_val    = b;
        immediate       = imm;
        pc_in           = pc;
        dst_reg_addr    = dst;
        new_inst_tag_in = tag;
        do begin
            @(negedge clk);
            acc = alu_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got not accepted, want accepted (t=%0t)", $time);
        end
        rs_valid = 1'b0;
    endtask

    task automatic check_logs(input string name);
        check({name, "_res_count"}, res_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < res_log.size(); i++)
            check({name, "_res"}, res_log[i], exp_q[i]);
        check({name, "_br_count"}, br_log.size(), exp_br_q.size());
        for (int i = 0; i < exp_br_q.size() && i < br_log.size(); i++)
            check({name, "_br"}, br_log[i], exp_br_q[i]);
        res_log.delete();
        br_log.delete();
        exp_q.delete();
        exp_br_q.delete();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; rs_valid = 1'b0; flush = 1'b0; cdb_ready = 1'b1;
        src_reg1_val = 0; src_reg2_val = 0; immediate = 0; pc_in = 0;
        dst_reg_addr = 0; new_inst_tag_in = 0;
        control = '{alu_op: add_op, alu_src: src_reg2, is_branch_op: 1'b0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        check("rst_alu_valid", alu_valid, 0);
        check("rst_br_valid", br_valid, 0);
        check("rst_result_val", result_val, 0);
        check("rst_result_addr", result_addr, 0);
        check("rst_tag_out", new_inst_tag_out, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_alu_ready", alu_ready, 1);

        // add 5 + 7 appears two cycles after issue
        issue(add_op, 0, 0, 5, 7, 0, 0, 3, 1);
        step(1);
        check("add_alu_valid", alu_valid, 1);
        check("add_result", result_val, 12);
        check("add_addr", result_addr, 3);
        check("add_tag", new_inst_tag_out, 1);
        exp_q.push_back(12);
        step(3);
        check_logs("add");

        // Back-to-back sra / sltu / slt
        issue(sra_op,  0, 0, 32'h8000_0000, 4, 0, 0, 4, 2);
        issue(sltu_op, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 5, 3);
        issue(slt_op,  0, 0, 32'hFFFF_FFFF, 1, 0, 0, 6, 4);
        exp_q.push_back(32'hF800_0000); exp_q.push_back(0); exp_q.push_back(1);
        step(4);
        check_logs("shift_cmp");

        // Remaining ops, immediate source, unknown op
        issue(sub_op, 0, 0, 5, 7, 0, 0, 7, 5);                    exp_q.push_back(32'hFFFF_FFFE);
        issue(sll_op, 1, 0, 1, 0, 33, 0, 8, 6);                   exp_q.push_back(2);
        issue(srl_op, 0, 0, 32'h8000_0000, 4, 0, 0, 9, 7);        exp_q.push_back(32'h0800_0000);
        issue(xor_op, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 10, 8);     exp_q.push_back(32'h0FF0);
        issue(or_op,  0, 0, 32'hF0F0, 32'hFF00, 0, 0, 11, 9);     exp_q.push_back(32'hFFF0);
        issue(and_op, 1, 0, 32'hF0F0, 0, 32'hFF00, 0, 12, 10);    exp_q.push_back(32'hF000);
        issue(alu_op_t'(4'hF), 0, 0, 3, 4, 0, 0, 13, 11);         exp_q.push_back(0);
        step(4);
        check_logs("ops");

        // Branches
        issue(eq_op, 0, 1, 9, 9, 8, 32'h100, 0, 12);
        step(1);
        check("br_eq_valid", br_valid, 1);
        check("br_eq_taken", br_taken, 1);
        check("br_eq_pc", pc_out, 32'h110);
        check("br_eq_alu_valid", alu_valid, 0);
        exp_br_q.push_back({1'b1, 32'h110});
        issue(eq_op, 0, 1, 9, 8, 8, 32'h100, 0, 13);              exp_br_q.push_back({1'b0, 32'h104});
        issue(not_eq_op, 0, 1, 1, 2, 32'h10, 32'h200, 0, 14);     exp_br_q.push_back({1'b1, 32'h220});
        issue(less_than_op, 0, 1, 32'hFFFF_FFFF, 1, 4, 32'h300, 0, 15);
        exp_br_q.push_back({1'b1, 32'h308});
        issue(greater_equal_than_op, 0, 1, 32'hFFFF_FFFF, 1, 4, 32'h300, 0, 16);
        exp_br_q.push_back({1'b0, 32'h304});
        issue(greater_equal_than_op, 0, 1, 5, 5, 32'hFFFF_FFFC, 32'h100, 0, 17);
        exp_br_q.push_back({1'b1, 32'h0F8});
        issue(add_op, 0, 1, 5, 5, 8, 32'h40, 0, 18);              exp_br_q.push_back({1'b0, 32'h44});
        step(4);
        check_logs("branch");

        // Back-pressure: three adds with cdb_ready low for three cycles
        cdb_ready = 1'b0;
        fork
            begin
                issue(add_op, 0, 0, 10, 20, 0, 0, 20, 20);
                issue(add_op, 0, 0, 100, 1, 0, 0, 21, 21);
                issue(add_op, 0, 0, 32'hFFFF_FFFF, 2, 0, 0, 22, 22);
            end
            begin
                step(2);
                check("stall_ready_a", alu_ready, 0);
                check("stall_hold_a", result_val, 30);
                step(1);
                check("stall_ready_b", alu_ready, 0);
                check("stall_hold_b", result_val, 30);
                check("stall_hold_tag", new_inst_tag_out, 20);
                cdb_ready = 1'b1;
            end
        join
        exp_q.push_back(30); exp_q.push_back(101); exp_q.push_back(1);
        step(4);
        check_logs("stall");

        // Flush with two in flight plus a same-cycle issue
        issue(add_op, 0, 0, 1, 1, 0, 0, 30, 30);
        issue(add_op, 0, 0, 2, 2, 0, 0, 31, 31);
        flush = 1'b1;
        issue(eq_op, 0, 1, 1, 1, 4, 32'h80, 0, 0);
        flush = 1'b0;
`ifdef ALU_PIPE_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            check("flush_alu_valid", alu_valid, 0);
            check("flush_br_valid", br_valid, 0);
            check("flush_ready", alu_ready, 1);
            step(1);
        end
        exp_q.push_back(2);
`else
        step(3);
        exp_q.push_back(2); exp_q.push_back(4);
        exp_br_q.push_back({1'b1, 32'h88});
`endif
        step(2);
        check_logs("flush");

        // Asynchronous reset with two instructions in flight
        issue(add_op, 0, 0, 40, 2, 0, 0, 40, 9);
        issue(add_op, 0, 0, 50, 3, 0, 0, 41, 10);
        check("pre_rst_alu_valid", alu_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_alu_valid", alu_valid, 0);
        check("arst_result_val", result_val, 0);
        check("arst_result_addr", result_addr, 0);
        check("arst_tag_out", new_inst_tag_out, 0);
        check("arst_br_valid", br_valid, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        step(1);
        check("arst_ready_after", alu_ready, 1);
        check("arst_valid_after", alu_valid, 0);
        res_log.delete();
        br_log.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
